// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
// Streaming RV32I instruction assembler. Packs opcode/register/funct/immediate
// request fields into a 32-bit instruction word and tags each word with its
// byte address. Covers R, I-arith (including shifts), I-load, S and B formats.
// Unencodable requests produce NOP_WORD with out_err set and bump a saturating
// error counter. One registered output stage with valid/ready handshake.
//
// Ports
//   clk        in   1       clock, rising edge
//   reset      in   1       synchronous active-high reset
//   in_valid   in   1       request fields valid
//   in_ready   out  1       encoder can accept (combinational)
//   in_opcode  in   7       opcode
//   in_rd      in   5       destination register
//   in_rs1     in   5       source register 1
//   in_rs2     in   5       source register 2
//   in_funct3  in   3       funct3
//   in_funct7  in   7       funct7 (R-type, shifts)
//   in_imm     in   32      immediate, two's complement byte value
//   out_valid  out  1       output word valid
//   out_ready  in   1       consumer accepts word
//   out_instr  out  32      encoded word (NOP_WORD on error)
//   out_addr   out  ADDR_W  byte address of out_instr
//   out_err    out  1       request was unencodable
//   err_count  out  CNT_W   saturating count of accepted erroneous requests
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int unsigned        CNT_W     = 8,
    parameter logic [31:0]        NOP_WORD  = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_count
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [2:0] F3_SLL   = 3'b001;
    localparam logic [2:0] F3_SRX   = 3'b101;
    localparam logic [6:0] F7_ZERO  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

    logic              accept;
    logic [ADDR_W-1:0] next_addr;

    // Immediate legality flags
    logic imm12_ok;
    logic imm13_ok;
    logic shamt_ok;
    logic shift_f7_ok;

    logic [31:0] raw_word;
    logic        legal;
    logic [31:0] enc_word;

    // Handshake: the single output slot frees up when empty or being drained
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Range checks on the full 32-bit immediate: upper bits must be pure sign extension
    always_comb begin
        imm12_ok    = (in_imm[31:11] == 21'h0) || (in_imm[31:11] == 21'h1F_FFFF);
        imm13_ok    = ((in_imm[31:12] == 20'h0) || (in_imm[31:12] == 20'hF_FFFF)) && !in_imm[0];
        shamt_ok    = (in_imm[31:5] == 27'h0);
        shift_f7_ok = (in_funct7 == F7_ZERO) || ((in_funct3 == F3_SRX) && (in_funct7 == F7_ALT));
    end

    // Field packing per format
    always_comb begin
        raw_word = NOP_WORD;
        legal    = 1'b0;
        unique case (in_opcode)
            OP_R: begin
                raw_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                legal    = 1'b1;
            end
            OP_I: begin
                if ((in_funct3 == F3_SLL) || (in_funct3 == F3_SRX)) begin
                    raw_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                    legal    = shamt_ok && shift_f7_ok;
                end else begin
                    raw_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                    legal    = imm12_ok;
                end
            end
            OP_L: begin
                raw_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                legal    = imm12_ok;
            end
            OP_S: begin
                raw_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                legal    = imm12_ok;
            end
            OP_B: begin
                raw_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                legal    = imm13_ok;
            end
            default: begin
                raw_word = NOP_WORD;
                legal    = 1'b0;
            end
        endcase
        enc_word = legal ? raw_word : NOP_WORD;
    end

    // Output stage, address tagging and error counter
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_instr <= 32'h0;
            out_addr  <= BASE_ADDR;
            out_err   <= 1'b0;
            err_count <= '0;
            next_addr <= BASE_ADDR;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_instr <= enc_word;
            out_addr  <= next_addr;
            out_err   <= !legal;
            next_addr <= next_addr + ADDR_STEP;
            if (!legal && (err_count != {CNT_W{1'b1}})) begin
                err_count <= err_count + CNT_W'(1);
            end
        end else if (out_ready) begin
            // Drained with nothing new: data fields keep their last value
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
// Self-checking bench for instr_encoder: directed RV32I encodings, error
// cases, back-pressure, reset while holding, random traffic against a
// transaction-level reference model, plus a second instance for address
// wrap and counter saturation.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam logic [31:0] BASE2 = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic [7:0]  err_count;

    logic        in_valid2;
    logic        in_ready2;
    logic        out_valid2;
    logic        out_ready2;
    logic [31:0] out_instr2;
    logic [31:0] out_addr2;
    logic        out_err2;
    logic [1:0]  err_count2;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_next;
    int          m_cnt;

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(BASE), .CNT_W(8), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err),
        .err_count(err_count)
    );

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(BASE2), .CNT_W(2), .NOP_WORD(NOP)) dut2 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_opcode(7'b1111111), .in_rd(5'd0), .in_rs1(5'd0), .in_rs2(5'd0),
        .in_funct3(3'd0), .in_funct7(7'd0), .in_imm(32'd0),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_instr(out_instr2), .out_addr(out_addr2), .out_err(out_err2),
        .err_count(err_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference encoder written from the format rules with signed arithmetic
    function automatic exp_t model(input logic [6:0] op, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] imm_bits);
        exp_t r;
        int   imm;
        bit   ok;
        logic [31:0] w;
        imm = int'(imm_bits);
        ok  = 1'b0;
        w   = NOP;
        case (op)
            7'b0110011: begin
                ok = 1'b1;
                w  = {f7, rs2, rs1, f3, rd, op};
            end
            7'b0010011: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    ok = (imm >= 0) && (imm <= 31) &&
                         ((f7 == 7'h00) || (f3 == 3'b101 && f7 == 7'h20));
                    w  = {f7, imm_bits[4:0], rs1, f3, rd, op};
                end else begin
                    ok = (imm >= -2048) && (imm <= 2047);
                    w  = {imm_bits[11:0], rs1, f3, rd, op};
                end
            end
            7'b0000011: begin
                ok = (imm >= -2048) && (imm <= 2047);
                w  = {imm_bits[11:0], rs1, f3, rd, op};
            end
            7'b0100011: begin
                ok = (imm >= -2048) && (imm <= 2047);
                w  = {imm_bits[11:5], rs2, rs1, f3, imm_bits[4:0], op};
            end
            7'b1100011: begin
                ok = (imm >= -4096) && (imm <= 4094) && ((imm % 2) == 0);
                w  = {imm_bits[12], imm_bits[10:5], rs2, rs1, f3, imm_bits[4:1], imm_bits[11], op};
            end
            default: ok = 1'b0;
        endcase
        r.instr = ok ? w : NOP;
        r.err   = !ok;
        r.addr  = 32'h0;
        return r;
    endfunction

    // One clock of traffic on the main instance; entered and left at a negedge
    task automatic cycle(input logic v, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm, input logic rdy);
        exp_t e;
        logic exp_rdy;
        in_valid  = v;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        out_ready = rdy;
        #1;
        chk("sb_out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("sb_out_instr", out_instr, q[0].instr);
            chk("sb_out_addr", out_addr, q[0].addr);
            chk("sb_out_err", 32'(out_err), 32'(q[0].err));
        end
        chk("sb_err_count", 32'(err_count), 32'(m_cnt));
        exp_rdy = (q.size() == 0) || rdy;
        chk("sb_in_ready", 32'(in_ready), 32'(exp_rdy));
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if (v && exp_rdy) begin
            e      = model(op, rd, rs1, rs2, f3, f7, imm);
            e.addr = m_next;
            m_next = m_next + 32'd4;
            if (e.err && m_cnt < 255) m_cnt++;
            q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_valid2  = 1'b0;
        out_ready  = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        q.delete();
        m_next = BASE;
        m_cnt  = 0;
    endtask

    function automatic logic [31:0] rand_imm();
        int edges [14] = '{-4097, -4096, -4095, -2049, -2048, 2047, 2048,
                           4094, 4095, 4096, 31, 32, -1, 0};
        case ($urandom_range(0, 3))
            0:       return 32'(int'($urandom_range(0, 80)) - 40);
            1:       return 32'(edges[$urandom_range(0, 13)]);
            2:       return $urandom;
            default: return 32'(int'($urandom_range(0, 8191)) - 4096);
        endcase
    endfunction

    initial begin
        logic [6:0] ops [6] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                7'b0100011, 7'b1100011, 7'b1111111};
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_opcode  = '0;
        in_rd      = '0;
        in_rs1     = '0;
        in_rs2     = '0;
        in_funct3  = '0;
        in_funct7  = '0;
        in_imm     = '0;
        out_ready  = 1'b0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b1;
        @(negedge clk);
        do_reset();

        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_addr", out_addr, BASE);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // addi x1,x0,-1
        cycle(1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFF, 1);
        chk("addi_instr", out_instr, 32'hFFF0_0093);
        chk("addi_addr", out_addr, BASE);
        chk("addi_err", 32'(out_err), 32'd0);

        // sw x5,8(x2) then beq x1,x2,-4 back to back
        cycle(1, 7'b0100011, 5'd0, 5'd2, 5'd5, 3'b010, 7'd0, 32'd8, 1);
        chk("sw_instr", out_instr, 32'h0051_2423);
        chk("sw_addr", out_addr, BASE + 32'd4);
        cycle(1, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'hFFFF_FFFC, 1);
        chk("beq_instr", out_instr, 32'hFE20_8EE3);
        chk("beq_addr", out_addr, BASE + 32'd8);

        // srai x3,x4,5
        cycle(1, 7'b0010011, 5'd3, 5'd4, 5'd0, 3'b101, 7'b0100000, 32'd5, 1);
        chk("srai_instr", out_instr, 32'h4052_5193);

        // slli with shamt 32 is unencodable
        cycle(1, 7'b0010011, 5'd3, 5'd4, 5'd0, 3'b001, 7'd0, 32'd32, 1);
        chk("slli32_instr", out_instr, NOP);
        chk("slli32_err", 32'(out_err), 32'd1);
        chk("slli32_cnt", 32'(err_count), 32'd1);
        chk("slli32_addr", out_addr, BASE + 32'h10);

        // Odd branch offset, out-of-range I immediate, unknown opcode
        cycle(1, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3, 1);
        chk("b_odd_instr", out_instr, NOP);
        chk("b_odd_addr", out_addr, BASE + 32'h14);
        cycle(1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, 1);
        chk("i2048_err", 32'(out_err), 32'd1);
        chk("i2048_addr", out_addr, BASE + 32'h18);
        cycle(1, 7'b1111111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0, 1);
        chk("badop_instr", out_instr, NOP);
        chk("badop_addr", out_addr, BASE + 32'h1C);
        chk("badop_cnt", 32'(err_count), 32'd4);

        // add x1,x2,x3 then hold for three cycles
        cycle(1, 7'b0110011, 5'd1, 5'd2, 5'd3, 3'b000, 7'd0, 32'd0, 1);
        chk("add_instr", out_instr, 32'h0031_00B3);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 7'b0110011, 5'd4, 5'd5, 5'd6, 3'b000, 7'b0100000, 32'd0, 0);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_instr", out_instr, 32'h0031_00B3);
            chk("hold_addr", out_addr, BASE + 32'h20);
        end
        // Release: sub x4,x5,x6 accepted this edge, visible next
        cycle(1, 7'b0110011, 5'd4, 5'd5, 5'd6, 3'b000, 7'b0100000, 32'd0, 1);
        chk("sub_instr", out_instr, 32'h4062_8233);
        chk("sub_addr", out_addr, BASE + 32'h24);

        // Reset while a word is held
        cycle(0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        do_reset();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_cnt", 32'(err_count), 32'd0);
        chk("midrst_addr", out_addr, BASE);
        chk("midrst_instr", out_instr, 32'h0);
        cycle(1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFF, 1);
        chk("post_rst_addr", out_addr, BASE);

        // Random traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            logic [6:0] f7r;
            case ($urandom_range(0, 2))
                0:       f7r = 7'h00;
                1:       f7r = 7'h20;
                default: f7r = 7'($urandom);
            endcase
            cycle(1'($urandom_range(0, 3) != 0), ops[$urandom_range(0, 5)],
                  5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), f7r,
                  rand_imm(), 1'($urandom_range(0, 2) != 0));
        end
        cycle(0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1);
        cycle(0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1);

        // Second instance: address wrap and error counter saturation
        for (int i = 0; i < 6; i++) begin
            in_valid2 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("wrap_addr", out_addr2, BASE2 + 32'(4 * i));
            chk("wrap_instr", out_instr2, NOP);
            chk("wrap_err", 32'(out_err2), 32'd1);
            chk("sat_cnt", 32'(err_count2), 32'((i + 1 < 3) ? i + 1 : 3));
        end
        in_valid2 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
